// File: rtl/mcp_channel_arbiter.sv
// Round-robin arbiter sharing one MCP CDC channel source port between
// NUM_REQ valid/ready requesters. The accepted word is held stable and tagged
// with its requester index until the channel accepts it.
// Optional stall watchdog: define MCP_ARB_WDOG_EN to build it.
module mcp_channel_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WDOG_CYCLES = 1024,
    localparam int unsigned ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          chan_valid,
    output logic [DATA_WIDTH-1:0]         chan_data,
    output logic [ID_WIDTH-1:0]           chan_id,
    input  logic                          chan_ready,
    output logic                          wdog_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q;
    logic [ID_WIDTH-1:0]   rr_ptr_d;
    logic [ID_WIDTH-1:0]   win_idx;
    logic                  win_found;
    int unsigned           cand;
    logic                  chan_valid_d;
    logic [DATA_WIDTH-1:0] chan_data_d;
    logic [ID_WIDTH-1:0]   chan_id_d;
    logic                  chan_hs;

    assign chan_hs = chan_valid & chan_ready;

    // Rotating-priority search for the first valid requester at or after rr_ptr
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = 32'(rr_ptr_q) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req_valid[ID_WIDTH'(cand)]) begin
                win_found = 1'b1;
                win_idx   = ID_WIDTH'(cand);
            end
        end
    end

    // Next-state, next channel word and combinational requester accept
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        chan_valid_d = chan_valid;
        chan_data_d  = chan_data;
        chan_id_d    = chan_id;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    chan_valid_d       = 1'b1;
                    chan_data_d        = req_data[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    chan_id_d          = win_idx;
                    state_d            = GRANT;
                end
            end
            GRANT: begin
                if (chan_hs) begin
                    chan_valid_d = 1'b0;
                    rr_ptr_d     = (chan_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                      : chan_id + ID_WIDTH'(1);
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and registered channel outputs; reset drops any held word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            chan_valid <= 1'b0;
            chan_data  <= '0;
            chan_id    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            chan_valid <= chan_valid_d;
            chan_data  <= chan_data_d;
            chan_id    <= chan_id_d;
        end
    end

`ifdef MCP_ARB_WDOG_EN
    localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);

    logic [CNT_W-1:0] wdog_cnt;

    // Stall counter over GRANT cycles without a handshake; sticky error at the limit
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else if (state_q == IDLE) begin
            wdog_cnt <= '0;
        end else if (!chan_ready && (wdog_cnt != CNT_W'(WDOG_CYCLES))) begin
            wdog_cnt <= wdog_cnt + CNT_W'(1);
            if (wdog_cnt == CNT_W'(WDOG_CYCLES - 1)) begin
                wdog_err <= 1'b1;
            end
        end
    end
`else
    logic unused_wdog_cfg;

    // Watchdog not built: the limit is intentionally unused and the flag is tied low
    assign unused_wdog_cfg = ^WDOG_CYCLES;
    assign wdog_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mcp_channel_arbiter.sv
// Scoreboard bench for mcp_channel_arbiter (4 requesters, 32-bit payloads).
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_mcp_channel_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 32;
`ifdef MCP_ARB_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               chan_valid;
    logic [DW-1:0]      chan_data;
    logic [1:0]         chan_id;
    logic               chan_ready;
    logic               wdog_err;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mcp_channel_arbiter #(
        .NUM_REQ    (NREQ),
        .DATA_WIDTH (DW),
        .WDOG_CYCLES(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .chan_valid(chan_valid),
        .chan_data (chan_data),
        .chan_id   (chan_id),
        .chan_ready(chan_ready),
        .wdog_err  (wdog_err)
    );

    function automatic exp_t mk(input int id, input logic [31:0] data);
        exp_t e;
        e.id   = 2'(id);
        e.data = data;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        chan_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        chan_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({chan_valid, chan_data, chan_id, req_ready, wdog_err} !== '0) begin
                n_err++;
                $display("FAIL reset_idle c=%0d: valid=%b data=%h id=%0d ready=%b wdog=%b, required all 0",
                         c, chan_valid, chan_data, chan_id, req_ready, wdog_err);
            end
        end
    endtask

    task automatic test_single();
        exp_t e;
        @(negedge clk);
        req_data[2*DW +: DW] = 32'hDEADBEEF;
        req_valid  = 4'b0100;
        chan_ready = 1'b1;
        exp_q.push_back(mk(2, 32'hDEADBEEF));
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++; $display("FAIL single_ready: got %b required 0100", req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_err++; $display("FAIL single_ready_pulse: got %b required 0000", req_ready);
        end
        req_valid = '0;
        n_cmp++;
        if (chan_valid !== 1'b1 || exp_q.size() == 0) begin
            n_err++; $display("FAIL single_chan_valid: got %b required 1", chan_valid);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (chan_id !== e.id || chan_data !== e.data) begin
                n_err++; $display("FAIL single_word: got id=%0d data=%h required id=%0d data=%h",
                                  chan_id, chan_data, e.id, e.data);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (chan_valid !== 1'b0 || req_ready !== 4'b0000) begin
            n_err++; $display("FAIL single_drop: got valid=%b ready=%b required 0/0000", chan_valid, req_ready);
        end
    endtask

    task automatic test_rr();
        int   cnt[NREQ];
        int   pend   = -1;
        int   acc_k  = 0;
        int   n_hs   = 0;
        int   last   = 0;
        int   cyc    = 0;
        logic [NREQ-1:0] exp_rdy;
        exp_t e;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 0;
            req_data[i*DW +: DW] = {8'(8'hC0 + i), 24'h0};
        end
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(mk(k % 4, {8'(8'hC0 + k % 4), 24'(k / 4)}));
        end
        req_valid  = 4'hF;
        chan_ready = 1'b1;
        #1;
        while (cyc < 40) begin
            if (req_ready != '0) begin
                if (acc_k < 6) begin
                    exp_rdy = 4'b0001 << (acc_k % 4);
                    n_cmp++;
                    if (req_ready !== exp_rdy) begin
                        n_err++; $display("FAIL rr_accept k=%0d: got %b required %b", acc_k, req_ready, exp_rdy);
                    end
                end
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) pend = i;
                acc_k++;
            end
            if (chan_valid && chan_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (chan_id !== e.id || chan_data !== e.data) begin
                    n_err++; $display("FAIL rr_word n=%0d: got id=%0d data=%h required id=%0d data=%h",
                                      n_hs, chan_id, chan_data, e.id, e.data);
                end
                if (n_hs > 0) begin
                    n_cmp++;
                    if (cyc - last !== 2) begin
                        n_err++; $display("FAIL rr_spacing n=%0d: got %0d cycles required 2", n_hs, cyc - last);
                    end
                end
                last = cyc;
                n_hs++;
                if (n_hs == 6) break;
            end
            @(negedge clk);
            cyc++;
            if (pend >= 0) begin
                cnt[pend]++;
                req_data[pend*DW +: DW] = {8'(8'hC0 + pend), 24'(cnt[pend])};
                pend = -1;
            end
            #1;
        end
        req_valid = '0;
        n_cmp++;
        if (n_hs != 6) begin
            n_err++; $display("FAIL rr_timeout: got %0d transfers required 6", n_hs);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        // previous handshake was requester 1, so the pointer now sits at 2
        @(negedge clk);
        req_data[1*DW +: DW] = 32'h5A5A1234;
        req_valid  = 4'b0010;
        chan_ready = 1'b0;
        exp_q.push_back(mk(1, 32'h5A5A1234));
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_err++; $display("FAIL stall_accept: got %b required 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1000;
        req_data[3*DW +: DW] = 32'h3333CAFE;
        for (int c = 0; c < 50; c++) begin
            #1;
            n_cmp++;
            if (chan_valid !== 1'b1 || chan_id !== 2'd1 || chan_data !== 32'h5A5A1234 || req_ready !== '0) begin
                n_err++; $display("FAIL stall_hold c=%0d: got valid=%b id=%0d data=%h ready=%b required 1/1/5a5a1234/0000",
                                  c, chan_valid, chan_id, chan_data, req_ready);
            end
            @(negedge clk);
        end
        chan_ready = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (chan_valid !== 1'b1 || chan_id !== e.id || chan_data !== e.data) begin
            n_err++; $display("FAIL stall_release: got valid=%b id=%0d data=%h required 1/%0d/%h",
                              chan_valid, chan_id, chan_data, e.id, e.data);
        end
        exp_q.push_back(mk(3, 32'h3333CAFE));
        @(negedge clk);
        n_cmp++;
        if (chan_valid !== 1'b0 || req_ready !== 4'b1000) begin
            n_err++; $display("FAIL stall_next_arb: got valid=%b ready=%b required 0/1000", chan_valid, req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        e = exp_q.pop_front();
        n_cmp++;
        if (chan_valid !== 1'b1 || chan_id !== e.id || chan_data !== e.data) begin
            n_err++; $display("FAIL stall_second: got valid=%b id=%0d data=%h required 1/%0d/%h",
                              chan_valid, chan_id, chan_data, e.id, e.data);
        end
        @(negedge clk);
        n_cmp++;
        if (chan_valid !== 1'b0 || req_ready !== '0) begin
            n_err++; $display("FAIL stall_single_hs: got valid=%b ready=%b required 0/0000", chan_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        int   pend = -1;
        int   cyc  = 0;
        exp_t e;
        @(negedge clk);
        req_data[3*DW +: DW] = 32'h77770003;
        req_valid  = 4'b1000;
        chan_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (chan_valid !== 1'b1 || chan_id !== 2'd3) begin
            n_err++; $display("FAIL mid_grant: got valid=%b id=%0d required 1/3", chan_valid, chan_id);
        end
        req_valid = '0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({chan_valid, chan_data, chan_id, req_ready, wdog_err} !== '0) begin
            n_err++; $display("FAIL mid_reset: got valid=%b data=%h id=%0d ready=%b wdog=%b required all 0",
                              chan_valid, chan_data, chan_id, req_ready, wdog_err);
        end
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DW +: DW] = 32'hB0000000 + 32'(i);
            exp_q.push_back(mk(i, 32'hB0000000 + 32'(i)));
        end
        req_valid  = 4'hF;
        chan_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL mid_first_arb: got %b required 0001", req_ready);
        end
        while (exp_q.size() > 0 && cyc < 30) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) pend = i;
            if (chan_valid && chan_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (chan_id !== e.id || chan_data !== e.data) begin
                    n_err++; $display("FAIL mid_drain: got id=%0d data=%h required id=%0d data=%h",
                                      chan_id, chan_data, e.id, e.data);
                end
            end
            @(negedge clk);
            cyc++;
            if (pend >= 0) begin
                req_valid[pend] = 1'b0;
                pend = -1;
            end
            #1;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL mid_timeout: got %0d words left required 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_wdog();
        exp_t e;
        int   n_stall;
        n_stall = WDOG_ON ? 8 : 20;
        do_reset();
        req_data[0 +: DW] = 32'h0D0D0000;
        req_valid = 4'b0001;
        exp_q.push_back(mk(0, 32'h0D0D0000));
        @(negedge clk);
        req_valid = '0;
        for (int g = 1; g <= n_stall; g++) begin
            #1;
            n_cmp++;
            if (wdog_err !== 1'b0) begin
                n_err++; $display("FAIL wdog_early g=%0d: got %b required 0", g, wdog_err);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (wdog_err !== WDOG_ON) begin
            n_err++; $display("FAIL wdog_rise: got %b required %b", wdog_err, WDOG_ON);
        end
        chan_ready = 1'b1;
        e = exp_q.pop_front();
        n_cmp++;
        if (chan_valid !== 1'b1 || chan_id !== e.id || chan_data !== e.data) begin
            n_err++; $display("FAIL wdog_word: got valid=%b id=%0d data=%h required 1/%0d/%h",
                              chan_valid, chan_id, chan_data, e.id, e.data);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wdog_err !== WDOG_ON || chan_valid !== 1'b0) begin
            n_err++; $display("FAIL wdog_sticky: got err=%b valid=%b required %b/0", wdog_err, chan_valid, WDOG_ON);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (wdog_err !== 1'b0) begin
            n_err++; $display("FAIL wdog_clear: got %b required 0", wdog_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_stall();
        test_reset_mid();
        test_wdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
